// File: rtl/datapath_sequencer.sv
// Moore controller for the shared ALU / shifter / result-register datapath.
// Each operation runs a short fixed step program; all control outputs decode from state, latched opcode and step.
module datapath_sequencer #(
    parameter int W   = 8,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic           m1_sel,
    output logic           m2_sel,
    output logic           m3_sel,
    output logic           m4_sel,
    output logic           wrt_enable,
    output logic [3:0]     alu_control,
    output logic [SHW-1:0] shampt,
    output logic [1:0]     shift_control
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_NEG   = 2'b01;
    localparam logic [1:0] OP_MUL10 = 2'b10;
    localparam logic [1:0] OP_DUP   = 2'b11;

    localparam logic [3:0] ALU_NOT = 4'b1111;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_MOV = 4'b1101;
    localparam logic [3:0] ALU_ORR = 4'b1100;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;

    localparam logic [SHW-1:0] SH_ONE   = SHW'(1);
    localparam logic [SHW-1:0] SH_THREE = SHW'(3);
    localparam logic [SHW-1:0] SH_HALF  = SHW'(W / 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] step_reg, step_next;
    logic [1:0] op_reg, op_next;

    // Step-program decode for the current (opcode, step) pair
    logic           in_table;
    logic           last_step;
    logic           c_m1, c_m2, c_m3, c_m4;
    logic [3:0]     c_alu;
    logic [SHW-1:0] c_sh;
    logic [1:0]     c_dir;

    always_comb begin
        in_table  = 1'b0;
        last_step = 1'b0;
        c_m1      = 1'b0;
        c_m2      = 1'b0;
        c_m3      = 1'b0;
        c_m4      = 1'b0;
        c_alu     = 4'b0000;
        c_sh      = '0;
        c_dir     = SH_LSL;
        case ({op_reg, step_reg})
            {OP_LOAD, 2'd0}: begin
                in_table  = 1'b1;
                last_step = 1'b1;
                c_m2      = 1'b1;
                c_alu     = ALU_MOV;
            end
            {OP_NEG, 2'd0}: begin
                in_table = 1'b1;
                c_m2     = 1'b1;
                c_alu    = ALU_NOT;
            end
            {OP_NEG, 2'd1}: begin
                // register + constant 1 completes the two's complement
                in_table  = 1'b1;
                last_step = 1'b1;
                c_alu     = ALU_ADD;
            end
            {OP_MUL10, 2'd0}: begin
                in_table = 1'b1;
                c_sh     = SH_THREE;
                c_m4     = 1'b1;
                c_alu    = ALU_MOV;
            end
            {OP_MUL10, 2'd1}: begin
                // 8x already in the register, add 2x from the shifter
                in_table  = 1'b1;
                last_step = 1'b1;
                c_sh      = SH_ONE;
                c_m4      = 1'b1;
                c_alu     = ALU_ADD;
            end
            {OP_DUP, 2'd0}: begin
                in_table = 1'b1;
                c_sh     = SH_HALF;
                c_dir    = SH_LSR;
                c_m4     = 1'b1;
                c_alu    = ALU_MOV;
            end
            {OP_DUP, 2'd1}: begin
                in_table = 1'b1;
                c_m3     = 1'b1;
                c_sh     = SH_HALF;
                c_m4     = 1'b1;
                c_alu    = ALU_MOV;
            end
            {OP_DUP, 2'd2}: begin
                in_table  = 1'b1;
                last_step = 1'b1;
                c_sh      = SH_HALF;
                c_dir     = SH_LSR;
                c_m4      = 1'b1;
                c_alu     = ALU_ORR;
            end
            default: begin
                in_table = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            step_reg  <= 2'd0;
            op_reg    <= 2'b00;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            op_reg    <= op_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        op_next    = op_reg;
        case (state_reg)
            S_IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    op_next    = op;
                    step_next  = 2'd0;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (abort) begin
                    state_next = S_IDLE;
                    step_next  = 2'd0;
                end else if (!in_table || last_step) begin
                    state_next = S_DONE;
                    step_next  = 2'd0;
                end else begin
                    step_next = step_reg + 2'd1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                step_next  = 2'd0;
            end
            default: begin
                state_next = S_IDLE;
                step_next  = 2'd0;
            end
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        wrt_enable    = 1'b0;
        m1_sel        = 1'b0;
        m2_sel        = 1'b0;
        m3_sel        = 1'b0;
        m4_sel        = 1'b0;
        alu_control   = 4'b0000;
        shampt        = '0;
        shift_control = 2'b00;
        case (state_reg)
            S_EXEC: begin
                if (in_table) begin
                    busy          = 1'b1;
                    wrt_enable    = 1'b1;
                    m1_sel        = c_m1;
                    m2_sel        = c_m2;
                    m3_sel        = c_m3;
                    m4_sel        = c_m4;
                    alu_control   = c_alu;
                    shampt        = c_sh;
                    shift_control = c_dir;
                end
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: drives a small ALU/shifter/register datapath from the controller
// and checks status and register contents against an arithmetic model of each operation.
module tb_datapath_sequencer;

    localparam int W   = 8;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     op = 2'b00;
    logic           abort = 1'b0;
    logic           busy, done, m1_sel, m2_sel, m3_sel, m4_sel, wrt_enable;
    logic [3:0]     alu_control;
    logic [SHW-1:0] shampt;
    logic [1:0]     shift_control;

    int tests = 0;
    int fails = 0;

    datapath_sequencer #(.W(W), .SHW(SHW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .abort(abort),
        .busy(busy), .done(done), .m1_sel(m1_sel), .m2_sel(m2_sel),
        .m3_sel(m3_sel), .m4_sel(m4_sel), .wrt_enable(wrt_enable),
        .alu_control(alu_control), .shampt(shampt), .shift_control(shift_control)
    );

    always #5 clk = ~clk;

    // Datapath under control of the sequencer
    logic [W-1:0] data = '0;
    logic [W-1:0] dp_reg, sh_in, sh_out, a_in, b_in, alu_out;

    always_comb begin
        sh_in  = m3_sel ? dp_reg : data;
        sh_out = (shift_control == 2'b01) ? (sh_in >> shampt) : (sh_in << shampt);
        a_in   = m1_sel ? sh_out : dp_reg;
        b_in   = m2_sel ? data : (m4_sel ? sh_out : W'(1));
        case (alu_control)
            4'b1111: alu_out = ~b_in;
            4'b0100: alu_out = a_in + b_in;
            4'b1101: alu_out = b_in;
            4'b1100: alu_out = a_in | b_in;
            default: alu_out = a_in;
        endcase
    end

    always @(posedge clk or posedge reset) begin
        if (reset) dp_reg <= '0;
        else if (wrt_enable) dp_reg <= alu_out;
    end

    // Reference: number of register writes per op and the value after each write
    function automatic int steps_of(input logic [1:0] o);
        case (o)
            2'b00:   return 1;
            2'b11:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] step_val(input logic [1:0] o, input logic [7:0] d, input int i);
        int v;
        int hi;
        v  = int'(d);
        hi = v / 16;
        case (o)
            2'b00:   return d;
            2'b01:   return (i == 0) ? 8'(255 - v) : 8'((256 - v) % 256);
            2'b10:   return (i == 0) ? 8'(v * 8) : 8'(v * 10);
            default: begin
                if (i == 0) return 8'(hi);
                else if (i == 1) return 8'(hi * 16);
                else return 8'(hi * 16 + hi);
            end
        endcase
    endfunction

    // m_k: 0 idle, 1..steps one write per cycle, steps+1 the done cycle
    int         m_k = 0;
    logic [1:0] m_op = 2'b00;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_reg = 8'h00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_k    <= 0;
            m_op   <= 2'b00;
            m_data <= 8'h00;
            m_reg  <= 8'h00;
        end else if (m_k == 0) begin
            if (start && !abort) begin
                m_k    <= 1;
                m_op   <= op;
                m_data <= data;
            end
        end else if (m_k <= steps_of(m_op)) begin
            m_reg <= step_val(m_op, m_data, m_k - 1);
            m_k   <= abort ? 0 : m_k + 1;
        end else begin
            m_k <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] ctrl_vec();
        return {m1_sel, m2_sel, m3_sel, m4_sel, alu_control, shampt, shift_control};
    endfunction

    always @(negedge clk) begin
        int n;
        n = steps_of(m_op);
        chk("status", {29'd0, busy, done, wrt_enable},
            {29'd0, m_k >= 1, m_k == n + 1, (m_k >= 1) && (m_k <= n)});
        chk("reg", {24'd0, dp_reg}, {24'd0, m_reg});
        if (m_k == 0) chk("idle_ctrl", {17'd0, ctrl_vec()}, 32'd0);
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [7:0] d,
                          input int lat, input logic [23:0] exp_seq);
        int cyc;
        logic [7:0] seen[$];
        op = o;
        data = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            seen.push_back(dp_reg);
        end
        chk({name, "_latency"}, 32'(cyc), 32'(lat));
        for (int i = 0; i < lat - 1; i++) begin
            if (i < seen.size()) chk({name, "_step"}, {24'd0, seen[i]}, {24'd0, exp_seq[8*i +: 8]});
            else chk({name, "_step_missing"}, 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        chk({name, "_back_idle"}, {31'd0, busy}, 32'd0);
        $display("[TB] op=%0d data=0x%02h latency=%0d reg=0x%02h", o, d, cyc, dp_reg);
    endtask

    initial begin
        #1 reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs", {15'd0, busy, done, wrt_enable, ctrl_vec()}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors with hand-computed register sequences
        run_op("load", 2'b00, 8'h3C, 2, {16'h0, 8'h3C});
        run_op("neg", 2'b01, 8'h05, 3, {8'h0, 8'hFB, 8'hFA});
        run_op("mul10", 2'b10, 8'h07, 3, {8'h0, 8'h46, 8'h38});
        run_op("dup", 2'b11, 8'hA3, 4, {8'hAA, 8'hA0, 8'h0A});

        // Start with a different op while busy is ignored
        op = 2'b01; data = 8'h05; start = 1'b1;
        @(posedge clk); #1;
        op = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start_reg_s0", {24'd0, dp_reg}, 32'h0FA);
        @(posedge clk); #1;
        chk("busy_start_done", {31'd0, done}, 32'd1);
        chk("busy_start_reg", {24'd0, dp_reg}, 32'h0FB);
        @(posedge clk); #1;
        $display("[TB] start-while-busy: reg=0x%02h", dp_reg);

        // Abort after the first NEG write
        op = 2'b01; data = 8'h05; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_reg", {24'd0, dp_reg}, 32'h0FA);
        begin
            bit saw_done;
            saw_done = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                if (done) saw_done = 1'b1;
            end
            chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        end
        $display("[TB] abort: reg=0x%02h", dp_reg);

        // abort and start together in idle
        op = 2'b11; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", {31'd0, busy}, 32'd0);
        $display("[TB] abort+start idle: busy=%0b", busy);

        // Asynchronous reset during DUP step 1
        op = 2'b11; data = 8'hA3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("dup_before_reset", {31'd0, wrt_enable}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset", {15'd0, busy, done, wrt_enable, ctrl_vec()}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        $display("[TB] async reset mid-DUP: busy=%0b", busy);
        run_op("load_after_reset", 2'b00, 8'h5A, 2, {16'h0, 8'h5A});

        // Randomized traffic; data only changes when a start will be accepted
        repeat (600) begin
            @(posedge clk); #1;
            abort = ($urandom_range(0, 7) == 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 2'($urandom);
            if (m_k == 0 && start && !abort) begin
                data = 8'($urandom);
                $display("[TB] rand start op=%0d data=0x%02h expect=0x%02h", op, data,
                         step_val(op, data, steps_of(op) - 1));
            end
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
